// File: rtl/ex_issue_stage_pkg.sv
// rtl/ex_issue_stage_pkg.sv - ALUOp codes, issue-stage state codes and forwarding selects
// Shared by ex_issue_stage and its operand forwarding mux.
package ex_issue_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int OPW_DEF  = 5;

  // ALUOp codes of the EX-stage ALU
  localparam logic [4:0] ALUOP_NOP   = 5'd0;
  localparam logic [4:0] ALUOP_LUI   = 5'd1;
  localparam logic [4:0] ALUOP_AUIPC = 5'd2;
  localparam logic [4:0] ALUOP_ADD   = 5'd3;
  localparam logic [4:0] ALUOP_SUB   = 5'd4;
  localparam logic [4:0] ALUOP_XOR   = 5'd5;
  localparam logic [4:0] ALUOP_OR    = 5'd6;
  localparam logic [4:0] ALUOP_AND   = 5'd7;
  localparam logic [4:0] ALUOP_SLL   = 5'd8;
  localparam logic [4:0] ALUOP_SRL   = 5'd9;
  localparam logic [4:0] ALUOP_SRA   = 5'd10;
  localparam logic [4:0] ALUOP_SLT   = 5'd11;
  localparam logic [4:0] ALUOP_SLTU  = 5'd12;

  typedef enum logic [1:0] {
    ISSUE_EMPTY  = 2'b00,
    ISSUE_FULL   = 2'b01,
    ISSUE_BUBBLE = 2'b10
  } issue_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  // rs2 matters for R-type/branches (B from rs2) and for stores (imm B, rs2 is store data, no rd write)
  function automatic logic rs2_used(input logic bsel, input logic rd_we, input logic is_load);
    return !bsel || (!rd_we && !is_load);
  endfunction

endpackage

// File: rtl/ex_issue_stage_fwd_mux.sv
// rtl/ex_issue_stage_fwd_mux.sv - priority operand selector EX > MEM > WB > regfile
// x0 always reads as zero and is never matched against a producer.
module ex_issue_stage_fwd_mux
  import ex_issue_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_en,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_we,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data,
  output fwd_sel_e        sel
);

  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if (rs == 5'd0) begin
      data = '0;
    end else if (ex_en && (ex_rd == rs)) begin
      sel  = FWD_EX;
      data = ex_data;
    end else if (mem_we && (mem_rd == rs)) begin
      sel  = FWD_MEM;
      data = mem_data;
    end else if (wb_we && (wb_rd == rs)) begin
      sel  = FWD_WB;
      data = wb_data;
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// rtl/ex_issue_stage.sv - ID/EX issue register feeding the ALU with forwarded operands
// EX_FORWARD_EN enables the forwarding network; without it RAW hazards stall until WB has written.
module ex_issue_stage
  import ex_issue_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OPW  = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [OPW-1:0]  in_aluop,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_bsel,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic            in_is_load,
  input  logic [XLEN-1:0] ex_result,
  input  logic [4:0]      mem_rd,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_data,
  input  logic [4:0]      wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [OPW-1:0]  out_aluop,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_is_load
);

  issue_state_e    state_q;
  issue_state_e    state_d;
  logic            out_leave;
  logic            slot_free;
  logic            ex_en;
  logic            rs2_use;
  logic            hazard_stall;
  logic            bubble_go;
  logic            capture;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  fwd_sel_e        sel_rs1;
  fwd_sel_e        sel_rs2;

  assign out_valid = (state_q == ISSUE_FULL);
  assign out_leave = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  assign rs2_use   = rs2_used(in_bsel, in_rd_we, in_is_load);

`ifdef EX_FORWARD_EN
  // Only a non-load entry that is actually leaving has its result on ex_result this cycle
  assign ex_en        = out_leave && out_rd_we && !out_is_load;
  assign hazard_stall = out_valid && out_is_load && (out_rd != 5'd0) &&
                        ((out_rd == in_rs1) || (rs2_use && (out_rd == in_rs2)));
  assign bubble_go    = in_valid && hazard_stall && out_leave;
`else
  // Any held writer counts as in flight; a match on any producer means the regfile value is stale
  assign ex_en        = out_valid && out_rd_we;
  assign hazard_stall = (sel_rs1 != FWD_RF) || (rs2_use && (sel_rs2 != FWD_RF));
  assign bubble_go    = 1'b0;
`endif

  assign in_ready = (state_q != ISSUE_BUBBLE) && slot_free && !hazard_stall;
  assign capture  = in_valid && in_ready && !flush;

  ex_issue_stage_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs       (in_rs1),
    .rf_data  (in_rs1_val),
    .ex_en    (ex_en),
    .ex_rd    (out_rd),
    .ex_data  (ex_result),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .data     (fwd_rs1),
    .sel      (sel_rs1)
  );

  ex_issue_stage_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs       (in_rs2),
    .rf_data  (in_rs2_val),
    .ex_en    (ex_en),
    .ex_rd    (out_rd),
    .ex_data  (ex_result),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .data     (fwd_rs2),
    .sel      (sel_rs2)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE_EMPTY: begin
        if (capture) state_d = ISSUE_FULL;
      end
      ISSUE_FULL: begin
        if (capture)        state_d = ISSUE_FULL;
        else if (bubble_go) state_d = ISSUE_BUBBLE;
        else if (out_leave) state_d = ISSUE_EMPTY;
      end
      ISSUE_BUBBLE: state_d = ISSUE_EMPTY;
      default:      state_d = ISSUE_EMPTY;
    endcase
    // A taken branch/jump kills the held entry, any same-cycle capture and a pending bubble
    if (flush) state_d = ISSUE_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ISSUE_EMPTY;
      out_a       <= '0;
      out_b       <= '0;
      out_rs2_val <= '0;
      out_aluop   <= OPW'(ALUOP_NOP);
      out_pc      <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_is_load <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        out_a       <= fwd_rs1;
        out_b       <= in_bsel ? in_imm : fwd_rs2;
        out_rs2_val <= fwd_rs2;
        out_aluop   <= in_aluop;
        out_pc      <= in_pc;
        out_rd      <= in_rd;
        out_rd_we   <= in_rd_we;
        out_is_load <= in_is_load;
      end else if (state_d != ISSUE_FULL) begin
        // Empty slot presents a nop to the ALU; the rest of the operand bus keeps its value
        out_aluop <= OPW'(ALUOP_NOP);
      end
    end
  end

endmodule
